// File: rtl/keypad_emulator.sv
// keypad_emulator: responder end of a 4x4 column-drive / row-sense keypad scan.
// Latency: a key pushed into an empty queue is pressed one edge later, and Row follows Col by one edge.
// Backpressure: key_ready = !fifo_full. abort flushes the queue and drops any push offered in the same cycle.
//
// Ports:
//   clk, rst_n          - single rising-edge clock, asynchronous active-low reset
//   key_valid/key_code  - hex key offered; taken on an edge where key_valid && key_ready
//   key_ready           - queue has room
//   abort               - synchronous flush of the queue plus release of the current key
//   Col                 - scanner column drive, active-low (C1..C4 = Col[3]..Col[0])
//   Row                 - registered row return, active-low (R1..R4 = Row[3]..Row[0]), idle 4'b1111
//   press_active        - high while a key is held down
//   busy                - a key is pressed or in its release gap, or keys are still queued
module keypad_emulator #(
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 500000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       abort,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       press_active,
  output logic       busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  // The timer counts down to zero, so a window of N cycles loads N-1.
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Key queue
  // ---------------------------------------------------------------------------
  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  state_t           state;
  logic [TMR_W-1:0] cnt;
  logic [3:0]       cur_key;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign key_ready  = !fifo_full;

  // abort wins over both ends of the queue, so a key offered alongside it is lost.
  assign push = key_valid && key_ready && !abort;
  assign pop  = (state == S_IDLE) && !fifo_empty && !abort;

  // Storage needs no reset: count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so the pointers wrap on their own.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Press sequencer: IDLE -> PRESS (HOLD_CYCLES) -> GAP (GAP_CYCLES) -> IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cur_key      <= 4'h0;
      press_active <= 1'b0;
    end else if (abort) begin
      state        <= S_IDLE;
      cnt          <= '0;
      press_active <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_key      <= mem[rd_ptr];
            cnt          <= HOLD_LOAD;
            state        <= S_PRESS;
            press_active <= 1'b1;
          end
        end
        S_PRESS: begin
          if (cnt == '0) begin
            cnt          <= GAP_LOAD;
            state        <= S_GAP;
            press_active <= 1'b0;
          end else begin
            cnt <= cnt - TMR_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - TMR_W'(1);
          end
        end
        default: begin
          state        <= S_IDLE;
          cnt          <= '0;
          press_active <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE) || !fifo_empty;

  // ---------------------------------------------------------------------------
  // Key map: which Col bit the held key watches and which Row pattern it returns
  // ---------------------------------------------------------------------------
  logic [1:0] key_col_sel;
  logic [3:0] key_row_pat;

  always_comb begin
    key_col_sel = 2'd3;
    key_row_pat = 4'b1111;
    case (cur_key)
      4'h1: begin key_col_sel = 2'd3; key_row_pat = 4'b0111; end
      4'h4: begin key_col_sel = 2'd3; key_row_pat = 4'b1011; end
      4'h7: begin key_col_sel = 2'd3; key_row_pat = 4'b1101; end
      4'hF: begin key_col_sel = 2'd3; key_row_pat = 4'b1110; end
      4'h2: begin key_col_sel = 2'd2; key_row_pat = 4'b0111; end
      4'h5: begin key_col_sel = 2'd2; key_row_pat = 4'b1011; end
      4'h8: begin key_col_sel = 2'd2; key_row_pat = 4'b1101; end
      4'h0: begin key_col_sel = 2'd2; key_row_pat = 4'b1110; end
      4'h3: begin key_col_sel = 2'd1; key_row_pat = 4'b0111; end
      4'h6: begin key_col_sel = 2'd1; key_row_pat = 4'b1011; end
      4'h9: begin key_col_sel = 2'd1; key_row_pat = 4'b1101; end
      4'hE: begin key_col_sel = 2'd1; key_row_pat = 4'b1110; end
      4'hA: begin key_col_sel = 2'd0; key_row_pat = 4'b0111; end
      4'hB: begin key_col_sel = 2'd0; key_row_pat = 4'b1011; end
      4'hC: begin key_col_sel = 2'd0; key_row_pat = 4'b1101; end
      4'hD: begin key_col_sel = 2'd0; key_row_pat = 4'b1110; end
      default: begin key_col_sel = 2'd3; key_row_pat = 4'b1111; end
    endcase
  end

  // Only the held key's own column matters; other low columns are ignored, so a
  // scanner driving several columns low at once still sees the row.
  // Being gated by the registered press_active, Row releases one edge after
  // abort ends a press, and the async reset releases it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Row <= 4'b1111;
    end else if (press_active && !Col[key_col_sel]) begin
      Row <= key_row_pat;
    end else begin
      Row <= 4'b1111;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: scoreboard bench for keypad_emulator (HOLD=16, GAP=8, depth 4).
// Stimulus pushes the expected press (key, length, spacing) into a queue; a monitor
// pops it on each press_active rise and checks Row every cycle against the key map.
module tb_keypad_emulator;

  localparam int HOLD   = 16;
  localparam int GAP    = 8;
  localparam int DEPTH  = 4;
  localparam int PERIOD = HOLD + GAP + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       abort = 1'b0;
  logic [3:0] Col = 4'hF;
  logic       key_ready;
  logic [3:0] Row;
  logic       press_active;
  logic       busy;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .abort       (abort),
    .Col         (Col),
    .Row         (Row),
    .press_active(press_active),
    .busy        (busy)
  );

  typedef struct {
    logic [3:0] code;
    int         len;       // expected press length, <0 = cut short by reset
    int         spacing;   // cycles since previous rise, 0 = unchecked
    bit         need_hit;  // Row must show the key at least once
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_count = 0;
  bit   rot_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Key map table: Col bit index (C1=3..C4=0) and returned row pattern.
  function automatic int key_col(input logic [3:0] c);
    case (c)
      4'h1, 4'h4, 4'h7, 4'hF: return 3;
      4'h2, 4'h5, 4'h8, 4'h0: return 2;
      4'h3, 4'h6, 4'h9, 4'hE: return 1;
      default:                return 0;
    endcase
  endfunction

  function automatic logic [3:0] key_row(input logic [3:0] c);
    case (c)
      4'h1, 4'h2, 4'h3, 4'hA: return 4'b0111;
      4'h4, 4'h5, 4'h6, 4'hB: return 4'b1011;
      4'h7, 4'h8, 4'h9, 4'hC: return 4'b1101;
      default:                return 4'b1110;
    endcase
  endfunction

  function automatic logic [3:0] rot_pat(input int c);
    case ((c / 4) % 4)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rot_en) Col = rot_pat(cyc);
    end
  endtask

  task automatic push(input logic [3:0] c);
    int n;
    key_valid = 1'b1;
    key_code  = c;
    n = 0;
    while (!key_ready && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) check("push_timeout", key_ready, 1);
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || press_active) && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) check("idle_timeout", busy | press_active, 0);
    step(2);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic       pa_prev;
    logic [3:0] col_prev;
    logic [3:0] er;
    exp_t       cur;
    bit         have_cur;
    bit         hit;
    int         plen;
    int         last_rise;
    pa_prev   = 1'b0;
    col_prev  = 4'hF;
    have_cur  = 1'b0;
    hit       = 1'b0;
    plen      = 0;
    last_rise = 0;
    cur       = '{code: 4'h0, len: 0, spacing: 0, need_hit: 1'b0};
    forever begin
      @(negedge clk);
      if (rst_n) begin
        er = 4'hF;
        if (pa_prev && have_cur && !col_prev[key_col(cur.code)]) er = key_row(cur.code);
        check("row", Row, er);
        if (pa_prev && Row != 4'hF) hit = 1'b1;
      end
      if (pa_prev && !press_active) begin
        if (cur.len >= 0) check("press_len", plen, cur.len);
        if (cur.need_hit) check("press_hit", hit, 1);
      end
      if (press_active && !pa_prev) begin
        rise_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          have_cur = 1'b0;
          $display("FAIL unexpected_press: press_active rose with no queued expectation (cycle %0d)", cyc);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          if (cur.spacing > 0) check("press_spacing", cyc - last_rise, cur.spacing);
        end
        last_rise = cyc;
        plen = 0;
        hit = 1'b0;
      end
      if (press_active) plen++;
      pa_prev  = press_active;
      col_prev = Col;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int rc;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_row", Row, 4'hF);
    check("reset_press_active", press_active, 0);
    check("reset_busy", busy, 0);
    check("reset_key_ready", key_ready, 1);
    rst_n = 1'b1;
    step(2);

    // Single key 5 (C2R2) with column 2 held low
    Col = 4'b1011;
    exp_q.push_back('{code: 4'h5, len: HOLD, spacing: 0, need_hit: 1'b1});
    key_valid = 1'b1;
    key_code  = 4'h5;
    step(1);                                 // E0: push
    key_valid = 1'b0;
    check("single_pa_e0", press_active, 0);
    check("single_busy_e0", busy, 1);
    step(1);                                 // E1: pop
    check("single_pa_e1", press_active, 1);
    check("single_row_e1", Row, 4'hF);
    step(1);                                 // E2
    check("single_row_e2", Row, 4'b1011);
    step(4);
    check("single_row_hold", Row, 4'b1011);
    Col = 4'b0111;
    step(1);
    check("single_col_switch", Row, 4'hF);
    Col = 4'b1011;
    step(1);
    check("single_col_back", Row, 4'b1011);
    wait_idle();

    // Full map with rotating columns
    rot_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{code: 4'(i), len: HOLD, spacing: (i == 0) ? 0 : PERIOD, need_hit: 1'b1});
      push(4'(i));
    end
    wait_idle();
    rot_en = 1'b0;
    Col = 4'hF;
    step(2);

    // Backpressure and cadence: 1,2,3,A,B back to back, then C
    exp_q.push_back('{code: 4'h1, len: HOLD, spacing: 0,      need_hit: 1'b0});
    exp_q.push_back('{code: 4'h2, len: HOLD, spacing: PERIOD, need_hit: 1'b0});
    exp_q.push_back('{code: 4'h3, len: HOLD, spacing: PERIOD, need_hit: 1'b0});
    exp_q.push_back('{code: 4'hA, len: HOLD, spacing: PERIOD, need_hit: 1'b0});
    exp_q.push_back('{code: 4'hB, len: HOLD, spacing: PERIOD, need_hit: 1'b0});
    exp_q.push_back('{code: 4'hC, len: HOLD, spacing: PERIOD, need_hit: 1'b0});
    key_valid = 1'b1;
    key_code = 4'h1; step(1);                // E0
    key_code = 4'h2; step(1);                // E1 (push + pop)
    key_code = 4'h3; step(1);                // E2
    key_code = 4'hA; step(1);                // E3
    key_code = 4'hB;
    check("bp_ready_before_fifth", key_ready, 1);
    step(1);                                 // E4: queue now full
    check("bp_ready_full", key_ready, 0);
    check("bp_busy", busy, 1);
    key_code = 4'hC;
    n = 0;
    while (!key_ready && n < 100) begin
      step(1);
      n++;
    end
    check("bp_wait_cycles", n, 22);
    step(1);                                 // C taken
    key_valid = 1'b0;
    wait_idle();

    // Abort during the fifth cycle of the first press, with 0x9 offered
    Col = 4'b0111;
    exp_q.push_back('{code: 4'h4, len: 5, spacing: 0, need_hit: 1'b1});
    push(4'h4);                              // E0
    push(4'h6);                              // E1
    push(4'hD);                              // E2
    step(3);                                 // now in press cycle 5
    abort = 1'b1;
    key_valid = 1'b1;
    key_code = 4'h9;
    step(1);                                 // E6
    abort = 1'b0;
    key_valid = 1'b0;
    check("abort_pa", press_active, 0);
    check("abort_row_lag", Row, 4'b1011);
    check("abort_busy", busy, 0);
    check("abort_key_ready", key_ready, 1);
    step(1);
    check("abort_row_release", Row, 4'hF);
    rc = rise_count;
    step(60);
    check("abort_no_press", rise_count, rc);
    check("abort_busy_after", busy, 0);

    // Reset mid-press of B (C4R2) with 7 queued behind it
    Col = 4'b1110;
    exp_q.push_back('{code: 4'hB, len: -1, spacing: 0, need_hit: 1'b0});
    push(4'hB);
    push(4'h7);
    step(4);
    check("rst_pre_row", Row, 4'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_row", Row, 4'hF);
    check("rst_press_active", press_active, 0);
    check("rst_busy", busy, 0);
    check("rst_key_ready", key_ready, 1);
    step(3);
    rst_n = 1'b1;
    rc = rise_count;
    step(60);
    check("rst_no_press", rise_count, rc);
    check("rst_busy_after", busy, 0);
    check("rst_row_after", Row, 4'hF);

    step(5);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
